// File: rtl/ram_pkg.sv
// Shared types and helpers for the handshaked data RAM: size encoding,
// byte-enable generation, alignment checking and load extension (64-bit max).
package ram_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  localparam int MAXDW = 64;

  function automatic logic [7:0] gen_be(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // ob is log2(bytes per word); anything wider than a word is illegal.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off,
                                      input logic [1:0] ob);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return (size > ob) || ((off & m) != 3'b000);
  endfunction

  function automatic logic [MAXDW-1:0] extend(input logic [MAXDW-1:0] raw, input logic [2:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [MAXDW-1:0] sh;
    logic [MAXDW-1:0] r;
    sh = raw >> {off, 3'b000};
    case (size)
      SZ_B:    r = {{56{sgn & sh[7]}},  sh[7:0]};
      SZ_H:    r = {{48{sgn & sh[15]}}, sh[15:0]};
      SZ_W:    r = {{32{sgn & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Byte-enabled single-port storage array with a registered read port that
// holds its value whenever no read is enabled (BRAM-inferable).
module ram_bank #(
  parameter  int DEPTH = 4096,
  parameter  int NB    = 4,
  localparam int WAW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [NB-1:0]   be,
  input  logic            re,
  input  logic [WAW-1:0]  addr,
  input  logic [NB*8-1:0] din,
  output logic [NB*8-1:0] dout
);

  logic [NB-1:0][7:0] mem_q [DEPTH];
  logic [NB*8-1:0]    dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem_q[addr][i] <= din[8*i +: 8];
    end
    if (re) dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/ram_hs.sv
// Handshaked data RAM: byte-address steering, alignment checks, load
// extension, 1- or 2-stage response pipeline and a saturating error counter.
module ram_hs
  import ram_pkg::*;
#(
  parameter  int DEPTH   = 4096,
  parameter  int DW      = 32,
  localparam int NB      = DW/8,
  localparam int OB      = $clog2(NB),
  localparam int AW      = $clog2(DEPTH)+OB,
  parameter  int OUT_REG = 0,
  parameter  int ECW     = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [AW-1:0]  req_addr,
  input  logic [1:0]     req_size,
  input  logic           req_signed,
  input  logic [DW-1:0]  req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_rdata,
  output logic           rsp_err,
  output logic [ECW-1:0] err_count
);

  logic          acc, s1_adv, req_err, arr_we, arr_re;
  logic [2:0]    off;
  logic [7:0]    be8;
  logic [DW-1:0] din, dout, s1_rdata;
  logic [63:0]   ext64;

  logic          s1_valid_q, s1_err_q, s1_we_q, s1_sgn_q;
  logic [2:0]    s1_off_q;
  logic [1:0]    s1_size_q;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  assign off     = 3'(req_addr[OB-1:0]);
  assign req_err = misaligned(req_size, off, 2'(OB));
  assign acc     = req_valid & req_ready;
  assign arr_we  = acc & req_we & ~req_err;
  assign arr_re  = acc & ~req_we & ~req_err;
  assign be8     = gen_be(req_size, off);
  assign din     = req_wdata << {off, 3'b000};
  assign req_ready = s1_adv;

  ram_bank #(.DEPTH(DEPTH), .NB(NB)) u_bank (
    .clk  (clk),
    .we   (arr_we),
    .be   (be8[NB-1:0]),
    .re   (arr_re),
    .addr (req_addr[AW-1:OB]),
    .din  (din),
    .dout (dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_off_q   <= '0;
      s1_size_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= acc;
      if (acc) begin
        s1_err_q  <= req_err;
        s1_we_q   <= req_we;
        s1_sgn_q  <= req_signed;
        s1_off_q  <= off;
        s1_size_q <= req_size;
      end
    end
  end

  // Stores and errors return zero data; the bank output is only meaningful for good loads.
  assign ext64    = extend(64'(dout), s1_off_q, s1_size_q, s1_sgn_q);
  assign s1_rdata = (s1_valid_q & ~s1_err_q & ~s1_we_q) ? ext64[DW-1:0] : '0;

  logic unused_ok;
  assign unused_ok = ^{ext64, be8};

  if (OUT_REG != 0) begin : g_s2
    logic          s2_valid_q, s2_err_q, s2_adv;
    logic [DW-1:0] s2_rdata_q;

    assign s2_adv = ~s2_valid_q | rsp_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_rdata_q <= '0;
      end else if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_valid_q & s1_err_q;
        s2_rdata_q <= s1_rdata;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_err   = s2_err_q;
    assign rsp_rdata = s2_rdata_q;
  end else begin : g_s1
    assign s1_adv    = ~s1_valid_q | rsp_ready;
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_valid_q & s1_err_q;
    assign rsp_rdata = s1_rdata;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_valid & rsp_ready & rsp_err & ~(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ram_hs.sv
// Directed bench for ram_hs: three instances (32-bit, 32-bit with output
// register, 64-bit) driven from one linear initial block.
module tb_ram_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rv[3], rr[3], we[3], sg[3];
  logic [10:0] addr[3];
  logic [1:0]  size[3];
  logic [63:0] wd[3];
  logic        req_ready[3], rsp_valid[3], rsp_err[3];
  logic [15:0] ecnt[3];
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;

  int errors = 0;
  int checks = 0;

  ram_hs #(.DEPTH(256), .DW(32), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(req_ready[0]), .req_we(we[0]),
    .req_addr(addr[0][9:0]), .req_size(size[0]), .req_signed(sg[0]), .req_wdata(wd[0][31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rr[0]), .rsp_rdata(rd0), .rsp_err(rsp_err[0]),
    .err_count(ecnt[0]));

  ram_hs #(.DEPTH(256), .DW(32), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(req_ready[1]), .req_we(we[1]),
    .req_addr(addr[1][9:0]), .req_size(size[1]), .req_signed(sg[1]), .req_wdata(wd[1][31:0]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rr[1]), .rsp_rdata(rd1), .rsp_err(rsp_err[1]),
    .err_count(ecnt[1]));

  ram_hs #(.DEPTH(256), .DW(64), .OUT_REG(0)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(req_ready[2]), .req_we(we[2]),
    .req_addr(addr[2]), .req_size(size[2]), .req_signed(sg[2]), .req_wdata(wd[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rr[2]), .rsp_rdata(rd2), .rsp_err(rsp_err[2]),
    .err_count(ecnt[2]));

  function automatic logic [63:0] get_rd(input int d);
    case (d)
      0:       return {32'h0, rd0};
      1:       return {32'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready=1; returns just after the response appears.
  task automatic xact(input int d, input logic w, input logic [10:0] a, input logic [1:0] sz,
                      input logic s, input logic [63:0] wdat, input logic [63:0] exp_rd,
                      input logic exp_err, input string tag);
    rv[d] = 1'b1; we[d] = w; addr[d] = a; size[d] = sz; sg[d] = s; wd[d] = wdat;
    #1 chk({tag, "_rdy"}, 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    if (d == 1) begin
      chk({tag, "_lat2"}, 64'(rsp_valid[d]), 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_vld"}, 64'(rsp_valid[d]), 64'd1);
    chk({tag, "_rd"},  get_rd(d), exp_rd);
    chk({tag, "_err"}, 64'(rsp_err[d]), 64'(exp_err));
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rr[i] = 1'b1; we[i] = 1'b0; sg[i] = 1'b0;
      addr[i] = '0; size[i] = '0; wd[i] = '0;
    end
    #12;
    chk("rst_vld",  64'(rsp_valid[0]), 64'd0);
    chk("rst_err",  64'(rsp_err[0]), 64'd0);
    chk("rst_rd",   64'(rd0), 64'd0);
    chk("rst_ecnt", 64'(ecnt[0]), 64'd0);
    chk("rst_rdy",  64'(req_ready[0]), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // 32-bit, no output register
    xact(0, 1, 11'h10, 2'd2, 0, 64'hDEADBEEF, 64'h0, 0, "st_w");
    xact(0, 0, 11'h10, 2'd2, 0, 64'h0, 64'hDEADBEEF, 0, "ld_w");
    xact(0, 1, 11'h13, 2'd0, 0, 64'h80, 64'h0, 0, "st_b");
    xact(0, 0, 11'h13, 2'd0, 1, 64'h0, 64'hFFFFFF80, 0, "ld_b_s");
    xact(0, 0, 11'h13, 2'd0, 0, 64'h0, 64'h00000080, 0, "ld_b_u");
    xact(0, 0, 11'h10, 2'd2, 0, 64'h0, 64'h80ADBEEF, 0, "ld_w2");
    xact(0, 0, 11'h12, 2'd1, 1, 64'h0, 64'hFFFF80AD, 0, "ld_h_s");
    xact(0, 0, 11'h11, 2'd1, 0, 64'h0, 64'h0, 1, "ld_h_mis");
    xact(0, 0, 11'h10, 2'd3, 0, 64'h0, 64'h0, 1, "ld_d_ill");
    chk("ecnt1", 64'(ecnt[0]), 64'd1);
    xact(0, 1, 11'h12, 2'd2, 0, 64'h11111111, 64'h0, 1, "st_w_mis");
    chk("ecnt2", 64'(ecnt[0]), 64'd2);
    xact(0, 0, 11'h10, 2'd2, 0, 64'h0, 64'h80ADBEEF, 0, "ld_w3");
    chk("ecnt3", 64'(ecnt[0]), 64'd3);

    // backpressure, latency 1
    @(posedge clk); #1;
    rr[0] = 1'b0;
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 11'h10; size[0] = 2'd2; sg[0] = 1'b0;
    #1 chk("bp_a_rdy", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    addr[0] = 11'h13; size[0] = 2'd0;
    #1 chk("bp_rdy0", 64'(req_ready[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_vld", 64'(rsp_valid[0]), 64'd1);
      chk("bp_hold_rd",  64'(rd0), 64'h80ADBEEF);
      chk("bp_hold_err", 64'(rsp_err[0]), 64'd0);
      chk("bp_hold_rdy", 64'(req_ready[0]), 64'd0);
    end
    rr[0] = 1'b1;
    #1 chk("bp_rdy1", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("bp_b_vld", 64'(rsp_valid[0]), 64'd1);
    chk("bp_b_rd",  64'(rd0), 64'h80);
    @(posedge clk); #1;
    chk("bp_drain", 64'(rsp_valid[0]), 64'd0);

    // 32-bit with output register
    xact(1, 1, 11'h10, 2'd2, 0, 64'hDEADBEEF, 64'h0, 0, "r_st_w");
    xact(1, 0, 11'h10, 2'd2, 0, 64'h0, 64'hDEADBEEF, 0, "r_ld_w");
    @(posedge clk); #1;
    rr[1] = 1'b0;
    rv[1] = 1'b1; we[1] = 1'b0; addr[1] = 11'h10; size[1] = 2'd2; sg[1] = 1'b0;
    @(posedge clk); #1;
    addr[1] = 11'h10; size[1] = 2'd0; sg[1] = 1'b1;
    #1 chk("r_bp_b_rdy", 64'(req_ready[1]), 64'd1);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    chk("r_bp_rdy0", 64'(req_ready[1]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("r_bp_vld", 64'(rsp_valid[1]), 64'd1);
      chk("r_bp_rd",  64'(rd1), 64'hDEADBEEF);
      chk("r_bp_rdy", 64'(req_ready[1]), 64'd0);
    end
    rr[1] = 1'b1;
    @(posedge clk); #1;
    chk("r_bp_b_vld", 64'(rsp_valid[1]), 64'd1);
    chk("r_bp_b_rd",  64'(rd1), 64'hFFFFFFEF);
    @(posedge clk); #1;
    chk("r_bp_drain", 64'(rsp_valid[1]), 64'd0);

    // 64-bit
    xact(2, 1, 11'h8, 2'd3, 0, 64'h0123456789ABCDEF, 64'h0, 0, "w_st_d");
    xact(2, 0, 11'hE, 2'd1, 1, 64'h0, 64'h0000000000000123, 0, "w_ld_h");
    xact(2, 0, 11'h9, 2'd0, 1, 64'h0, 64'hFFFFFFFFFFFFFFCD, 0, "w_ld_b");
    xact(2, 0, 11'hC, 2'd2, 1, 64'h0, 64'h0000000001234567, 0, "w_ld_w");
    xact(2, 0, 11'h8, 2'd3, 0, 64'h0, 64'h0123456789ABCDEF, 0, "w_ld_d");
    xact(2, 0, 11'hA, 2'd2, 0, 64'h0, 64'h0, 1, "w_ld_w_mis");

    // reset while a load response is stalled
    @(posedge clk); #1;
    rr[0] = 1'b0;
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 11'h10; size[0] = 2'd2; sg[0] = 1'b0;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("rm_vld", 64'(rsp_valid[0]), 64'd1);
    chk("rm_ecnt_pre", 64'(ecnt[0]), 64'd3);
    rst = 1'b1;
    #1;
    chk("rm_vld0", 64'(rsp_valid[0]), 64'd0);
    chk("rm_ecnt0", 64'(ecnt[0]), 64'd0);
    chk("rm_rd0", 64'(rd0), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    rr[0] = 1'b1;

    // store accepted just before reset is still committed
    xact(0, 1, 11'h10, 2'd0, 0, 64'h5A, 64'h0, 0, "st_pre_rst");
    rst = 1'b1;
    #1 chk("sr_vld0", 64'(rsp_valid[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    xact(0, 0, 11'h10, 2'd2, 0, 64'h0, 64'h80ADBE5A, 0, "ld_post_rst");
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
